// File: rtl/dmaster_bytes_to_packets.sv
// rtl/dmaster_bytes_to_packets.sv - escaped byte stream to Avalon-ST packet beat decoder
//
// Purpose: strips SOP/EOP/CHANNEL/ESCAPE framing codes from the host byte
// stream and emits 8-bit data beats with packet flags and channel.
//
// Optional feature macro: DMASTER_B2P_CHANNEL_EN
//   defined     - the byte after 0x7C loads the channel register; beats carry it.
//   not defined - the byte after 0x7C is consumed and discarded; out_channel is 0.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   byte input handshake, in_data is the encoded byte
//   out_valid/out_ready beat output handshake
//   out_data            decoded data byte
//   out_startofpacket   first beat of a packet
//   out_endofpacket     last beat of a packet
//   out_channel         channel of the current beat (CHANNEL_WIDTH bits)

module dmaster_bytes_to_packets #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel
);

  localparam logic [7:0] CODE_SOP  = 8'h7A;
  localparam logic [7:0] CODE_EOP  = 8'h7B;
  localparam logic [7:0] CODE_CHAN = 8'h7C;
  localparam logic [7:0] CODE_ESC  = 8'h7D;

  logic       esc;
  logic       chan_pend;
  logic       sop_pend;
  logic       eop_pend;

  logic       accept;
  logic       is_code;
  logic       is_data;
  logic       emit_beat;
  logic [7:0] value;

  // The output register is free when empty or being drained this cycle, so a
  // new byte can be taken in the same cycle the old beat leaves (no bubble).
  assign in_ready  = reset_n & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  // An escaped byte is never a code, whatever its value.
  assign value     = esc ? (in_data ^ 8'h20) : in_data;
  assign is_code   = ~esc & ((in_data == CODE_SOP)  | (in_data == CODE_EOP) |
                             (in_data == CODE_CHAN) | (in_data == CODE_ESC));
  assign is_data   = accept & ~is_code;
  // A data byte following a CHANNEL code is the channel number, not a beat.
  assign emit_beat = is_data & ~chan_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      esc       <= 1'b0;
      chan_pend <= 1'b0;
      sop_pend  <= 1'b0;
      eop_pend  <= 1'b0;
    end else if (accept) begin
      if (is_code) begin
        case (in_data)
          // Framing codes abandon an unfinished channel selection.
          CODE_SOP: begin
            sop_pend  <= 1'b1;
            chan_pend <= 1'b0;
          end
          CODE_EOP: begin
            eop_pend  <= 1'b1;
            chan_pend <= 1'b0;
          end
          CODE_CHAN: chan_pend <= 1'b1;
          // chan_pend is kept so an escaped channel value still lands there.
          CODE_ESC:  esc <= 1'b1;
          default:   ;
        endcase
      end else begin
        esc <= 1'b0;
        if (chan_pend) begin
          chan_pend <= 1'b0;
        end else begin
          sop_pend <= 1'b0;
          eop_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (emit_beat) begin
      out_valid         <= 1'b1;
      out_data          <= value;
      out_startofpacket <= sop_pend;
      out_endofpacket   <= eop_pend;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
  end

`ifdef DMASTER_B2P_CHANNEL_EN
  logic [CHANNEL_WIDTH-1:0] chan_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_reg <= '0;
    end else if (is_data && chan_pend) begin
      chan_reg <= value[CHANNEL_WIDTH-1:0];
    end
  end

  // Sampled only when a beat is launched, so a channel change never alters a
  // beat already waiting on the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_channel <= '0;
    end else if (emit_beat) begin
      out_channel <= chan_reg;
    end
  end
`else
  assign out_channel = '0;
`endif

endmodule

// File: tb/tb_dmaster_bytes_to_packets.sv
// tb/tb_dmaster_bytes_to_packets.sv - scoreboard bench for dmaster_bytes_to_packets

module tb_dmaster_bytes_to_packets;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [7:0] ch;
    int         acc_cyc;
    bit         chk_lat;
  } beat_t;

  beat_t exp_q[$];

  dmaster_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: inputs change at negedge+1, so negedge+2 sees the handshake
  // values that the next rising edge will use.
  always @(negedge clk) begin
    #2;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {out_data, out_startofpacket, out_endofpacket, out_channel},
                      {e.d, e.sop, e.eop, e.ch});
        if (e.chk_lat) check("beat_latency", cyc - e.acc_cyc, 1);
      end
    end
  end

  // Drive one byte and wait until it is accepted; optionally push the beat it
  // should produce.
  task automatic send(input logic [7:0] b, input bit is_beat, input logic [7:0] d,
                      input logic sop, input logic eop, input logic [7:0] ch, input bit lat);
    bit done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin
        done = 1;
        if (is_beat) exp_q.push_back('{d, sop, eop, ch, cyc, lat});
      end
      @(posedge clk);
    end
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, expected accept within 20 cycles", b);
    end
  endtask

  task automatic code(input logic [7:0] b);
    send(b, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic data(input logic [7:0] b, input logic [7:0] d, input logic sop,
                      input logic eop, input logic [7:0] ch);
    send(b, 1'b1, d, sop, eop, ch, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  logic [7:0] ch_a;
  logic [7:0] ch_b;

  initial begin
`ifdef DMASTER_B2P_CHANNEL_EN
    ch_a = 8'h05;
    ch_b = 8'h7C;
`else
    ch_a = 8'h00;
    ch_b = 8'h00;
`endif
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {out_valid, out_data, out_startofpacket, out_endofpacket, out_channel}, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #3 check("rel_in_ready", in_ready, 1);

    // Framing: 7A 11 22 7B 33
    code(8'h7A);
    data(8'h11, 8'h11, 1'b1, 1'b0, 8'h00);
    data(8'h22, 8'h22, 1'b0, 1'b0, 8'h00);
    code(8'h7B);
    data(8'h33, 8'h33, 1'b0, 1'b1, 8'h00);
    idle(3);

    // Single-beat packet with escaped 0x7A, then escaped 0x7D
    code(8'h7A);
    code(8'h7B);
    code(8'h7D);
    data(8'h5A, 8'h7A, 1'b1, 1'b1, 8'h00);
    code(8'h7D);
    data(8'h5D, 8'h7D, 1'b0, 1'b0, 8'h00);
    idle(3);

    // Channel selection, including an escaped channel value
    code(8'h7C);
    code(8'h05);
    code(8'h7A);
    data(8'h44, 8'h44, 1'b1, 1'b0, ch_a);
    code(8'h7C);
    code(8'h7D);
    code(8'h5C);
    code(8'h7B);
    data(8'h55, 8'h55, 1'b0, 1'b1, ch_b);
    idle(3);

    // SOP/EOP cancel a pending channel selection: 7C 7A 66 -> data beat, channel kept
    code(8'h7C);
    code(8'h7A);
    data(8'h66, 8'h66, 1'b1, 1'b0, ch_b);
    idle(3);

    // Backpressure: beat 11 held four cycles while 22 waits
    send(8'h11, 1'b1, 8'h11, 1'b0, 1'b0, ch_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h22;
      #2;
      check("bp_hold", {out_valid, out_data, in_ready}, {1'b1, 8'h11, 1'b0});
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    data(8'h22, 8'h22, 1'b0, 1'b0, ch_b);
    idle(3);

    // Reset mid-stream discards pending SOP and escape
    code(8'h7A);
    code(8'h7D);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #2 check("midrst_in_ready", {in_ready, out_valid}, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    code(8'h7B);
    data(8'h11, 8'h11, 1'b0, 1'b1, 8'h00);
    idle(3);

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
